// File: rtl/pae32_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pae32_pkg : shared types and constants for the PAE32 walker       |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package pae32_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_CHECK = 3'd2,
    ST_FILL  = 3'd3,
    ST_FAULT = 3'd4
  } ptw_state_t;

  localparam int PTE_V  = 0;
  localparam int PTE_U  = 1;
  localparam int PA_MSB = 31;
  localparam int PA_LSB = 16;

  localparam logic SEL_I = 1'b0;
  localparam logic SEL_D = 1'b1;

  function automatic logic [31:0] pte_addr(input logic [7:0] base_h8, input logic [7:0] va_h8);
    return {base_h8, 14'b0, va_h8, 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/pae32_ptw_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pae32_ptw_if : single-master PTE read handshake                   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface pae32_ptw_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_err;

  modport master (output mem_req, output mem_addr,
                  input mem_ack, input mem_rdata, input mem_err);
  modport slave  (input mem_req, input mem_addr,
                  output mem_ack, output mem_rdata, output mem_err);
endinterface
`default_nettype wire

// File: rtl/pae32_ptw_arb.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pae32_ptw_arb : I/D miss arbiter, round-robin or fixed D priority |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module pae32_ptw_arb
  import pae32_pkg::*;
#(
  parameter int RR_ARB = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pend,
  input  logic d_pend,
  input  logic update,
  input  logic served,
  output logic grant
);

  // Resets to D so that the I side wins the first tie.
  logic rr_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_last <= SEL_D;
    end else if (update) begin
      rr_last <= served;
    end
  end

  generate
    if (RR_ARB != 0) begin : g_rr
      always_comb begin
        grant = SEL_I;
        if (i_pend && d_pend) begin
          grant = ~rr_last;
        end else if (d_pend) begin
          grant = SEL_D;
        end
      end
    end else begin : g_fixed
      logic unused_rr;
      assign unused_rr = rr_last ^ i_pend;
      assign grant     = d_pend ? SEL_D : SEL_I;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/pae32_ptw.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pae32_ptw : PAE32 page-table walker and I/D TLB refill sequencer  |
// | Optional: PTW_TIMEOUT_EN adds a bus-ack timeout (TIMEOUT_CYC).    |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module pae32_ptw
  import pae32_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64,
  parameter int RR_ARB      = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mmu_enable,
  input  logic        supervisor_mode,
  input  logic [7:0]  ipte_h8,
  input  logic [7:0]  dpte_h8,
  input  logic        i_miss,
  input  logic [7:0]  iva_h8,
  input  logic        d_miss,
  input  logic [7:0]  dva_h8,
  pae32_ptw_if.master mem,
  output logic        tlb_we,
  output logic        tlb_sel,
  output logic [7:0]  tlb_va_h8,
  output logic [15:0] tlb_pa_h16,
  output logic        i_done,
  output logic        d_done,
  output logic        i_fault,
  output logic        d_fault,
  output logic        busy
);

  ptw_state_t  state, state_nx;
  logic        side, grant, finish, timeout_hit;
  logic        pte_v, pte_u, pte_err, req_r;
  logic [7:0]  va, sel_va, sel_base;
  logic [15:0] pa;
  logic [31:0] addr_r;
  logic        unused_rdata;

  pae32_ptw_arb #(.RR_ARB(RR_ARB)) u_arb (
    .clk    (clk),
    .rst    (rst),
    .i_pend (i_miss),
    .d_pend (d_miss),
    .update (finish),
    .served (side),
    .grant  (grant)
  );

  assign sel_va   = (grant == SEL_D) ? dva_h8  : iva_h8;
  assign sel_base = (grant == SEL_D) ? dpte_h8 : ipte_h8;

`ifdef PTW_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYC) > 0) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TO_W-1:0] to_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state != ST_REQ) begin
      to_cnt <= '0;
    end else if (!mem.mem_ack) begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  assign timeout_hit = (state == ST_REQ) && !mem.mem_ack && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYC;
  assign timeout_hit    = 1'b0;
`endif

  // A disabled walker still finishes its bus read, then leaves silently.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (mmu_enable && (i_miss || d_miss)) state_nx = ST_REQ;
      ST_REQ: begin
        if (mem.mem_ack)      state_nx = ST_CHECK;
        else if (timeout_hit) state_nx = mmu_enable ? ST_FAULT : ST_IDLE;
      end
      ST_CHECK: begin
        if (!mmu_enable)                                    state_nx = ST_IDLE;
        else if (pte_err || !pte_v || (!pte_u && !supervisor_mode)) state_nx = ST_FAULT;
        else                                                state_nx = ST_FILL;
      end
      ST_FILL, ST_FAULT: state_nx = ST_IDLE;
      default:           state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      side    <= SEL_I;
      va      <= '0;
      addr_r  <= '0;
      req_r   <= 1'b0;
      pa      <= '0;
      pte_v   <= 1'b0;
      pte_u   <= 1'b0;
      pte_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && state_nx == ST_REQ) begin
        side   <= grant;
        va     <= sel_va;
        addr_r <= pte_addr(sel_base, sel_va);
        req_r  <= 1'b1;
      end
      if (state == ST_REQ && state_nx != ST_REQ) begin
        req_r <= 1'b0;
      end
      if (state == ST_REQ && mem.mem_ack) begin
        pa      <= mem.mem_rdata[PA_MSB:PA_LSB];
        pte_v   <= mem.mem_rdata[PTE_V];
        pte_u   <= mem.mem_rdata[PTE_U];
        pte_err <= mem.mem_err;
      end
    end
  end

  assign unused_rdata = ^mem.mem_rdata[PA_LSB-1:PTE_U+1];

  assign mem.mem_req  = req_r;
  assign mem.mem_addr = addr_r;

  assign finish     = (state == ST_FILL) || (state == ST_FAULT);
  assign busy       = (state != ST_IDLE);
  assign tlb_we     = (state == ST_FILL);
  assign tlb_sel    = tlb_we & side;
  assign tlb_va_h8  = tlb_we ? va : 8'h00;
  assign tlb_pa_h16 = tlb_we ? pa : 16'h0000;
  assign i_done     = finish && (side == SEL_I);
  assign d_done     = finish && (side == SEL_D);
  assign i_fault    = (state == ST_FAULT) && (side == SEL_I);
  assign d_fault    = (state == ST_FAULT) && (side == SEL_D);

endmodule
`default_nettype wire

// File: tb/tb_pae32_ptw.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pae32_ptw : randomized bench for pae32_ptw, RR and fixed arb   |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_pae32_ptw;

  logic        clk = 1'b0;
  logic        rst, mmu_enable, supervisor_mode, i_miss, d_miss;
  logic [7:0]  ipte_h8, dpte_h8, iva_h8, dva_h8;

  logic        tlb_we, tlb_sel, i_done, d_done, i_fault, d_fault, busy;
  logic [7:0]  tlb_va_h8;
  logic [15:0] tlb_pa_h16;
  logic        f_tlb_we, f_tlb_sel, f_i_done, f_d_done, f_i_fault, f_d_fault, f_busy;
  logic [7:0]  f_tlb_va_h8;
  logic [15:0] f_tlb_pa_h16;

  pae32_ptw_if bus ();
  pae32_ptw_if fbus ();

  always #5 clk = ~clk;

  pae32_ptw #(.TIMEOUT_CYC(8), .RR_ARB(1)) dut (
    .clk(clk), .rst(rst), .mmu_enable(mmu_enable), .supervisor_mode(supervisor_mode),
    .ipte_h8(ipte_h8), .dpte_h8(dpte_h8), .i_miss(i_miss), .iva_h8(iva_h8),
    .d_miss(d_miss), .dva_h8(dva_h8), .mem(bus),
    .tlb_we(tlb_we), .tlb_sel(tlb_sel), .tlb_va_h8(tlb_va_h8), .tlb_pa_h16(tlb_pa_h16),
    .i_done(i_done), .d_done(d_done), .i_fault(i_fault), .d_fault(d_fault), .busy(busy)
  );

  pae32_ptw #(.TIMEOUT_CYC(8), .RR_ARB(0)) dut_fix (
    .clk(clk), .rst(rst), .mmu_enable(mmu_enable), .supervisor_mode(supervisor_mode),
    .ipte_h8(ipte_h8), .dpte_h8(dpte_h8), .i_miss(i_miss), .iva_h8(iva_h8),
    .d_miss(d_miss), .dva_h8(dva_h8), .mem(fbus),
    .tlb_we(f_tlb_we), .tlb_sel(f_tlb_sel), .tlb_va_h8(f_tlb_va_h8), .tlb_pa_h16(f_tlb_pa_h16),
    .i_done(f_i_done), .d_done(f_d_done), .i_fault(f_i_fault), .d_fault(f_d_fault), .busy(f_busy)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  logic last_d   = 1'b1;  // reference: side served last by the round-robin walker

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_bus(input logic ack, input logic [31:0] rdata, input logic err);
    bus.mem_ack  = ack;  bus.mem_rdata  = rdata;  bus.mem_err  = err;
    fbus.mem_ack = ack;  fbus.mem_rdata = rdata;  fbus.mem_err = err;
  endtask

  // One complete walk, started at a falling edge where both walkers are idle.
  task automatic walk(input logic im, input logic dm, input logic [31:0] rdata, input logic err,
                      input int waits, input logic drop_en, input logic keep);
    logic        s, fault, live, fill;
    logic [7:0]  va, fva;
    logic [31:0] addr, faddr;
    s     = (im && dm) ? ~last_d : dm;
    va    = s  ? dva_h8 : iva_h8;
    fva   = dm ? dva_h8 : iva_h8;
    addr  = ({24'h0, (s  ? dpte_h8 : ipte_h8)} << 24) | ({24'h0, va}  << 2);
    faddr = ({24'h0, (dm ? dpte_h8 : ipte_h8)} << 24) | ({24'h0, fva} << 2);
    fault = err | ~rdata[0] | (~rdata[1] & ~supervisor_mode);
    live  = ~drop_en;
    fill  = live & ~fault;
    i_miss = im;
    d_miss = dm;
    @(negedge clk);
    check_eq("req_start", {30'b0, bus.mem_req, busy}, 32'h3);
    check_eq("addr", bus.mem_addr, addr);
    check_eq("f_addr", fbus.mem_addr, faddr);
    if (drop_en) mmu_enable = 1'b0;
    for (int k = 1; k <= waits; k++) begin
      @(negedge clk);
      check_eq("req_hold", {31'b0, bus.mem_req && (bus.mem_addr == addr)}, 32'h1);
    end
    set_bus(1'b1, rdata, err);
    @(negedge clk);
    set_bus(1'b0, $urandom, 1'b0);
    check_eq("req_drop", {27'b0, bus.mem_req, fbus.mem_req, tlb_we, i_done, d_done}, 32'h0);
    @(negedge clk);
    check_eq("flags", {26'b0, i_done, d_done, i_fault, d_fault, tlb_we, tlb_sel},
             {26'b0, live & ~s, live & s, live & fault & ~s, live & fault & s, fill, fill & s});
    check_eq("tlb_va", {24'b0, tlb_va_h8}, fill ? {24'b0, va} : 32'h0);
    check_eq("tlb_pa", {16'b0, tlb_pa_h16}, fill ? {16'b0, rdata[31:16]} : 32'h0);
    check_eq("f_flags", {28'b0, f_i_done, f_d_done, f_tlb_we, f_tlb_sel},
             {28'b0, live & ~dm, live & dm, fill, fill & dm});
    check_eq("busy_end", {31'b0, busy}, {31'b0, live});
    if (live) last_d = s;
    if (!keep) begin
      i_miss = 1'b0;
      d_miss = 1'b0;
    end
    mmu_enable = 1'b1;
    @(negedge clk);
    check_eq("idle", {30'b0, busy, f_busy}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; mmu_enable = 1'b0; supervisor_mode = 1'b1;
    i_miss = 1'b0; d_miss = 1'b0;
    ipte_h8 = 8'h80; dpte_h8 = 8'h40; iva_h8 = 8'h12; dva_h8 = 8'h05;
    set_bus(1'b0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    check_eq("rst_outs", {24'b0, bus.mem_req, tlb_we, tlb_sel, i_done, d_done, i_fault, d_fault, busy}, 32'h0);
    check_eq("rst_addr", bus.mem_addr, 32'h0);
    check_eq("rst_tlb", {8'b0, tlb_va_h8, tlb_pa_h16}, 32'h0);
    rst = 1'b0;
    mmu_enable = 1'b1;
    @(negedge clk);

    // Directed: I fill, D user-fault, RR rounds, bus error, enable dropped mid-read
    walk(1'b1, 1'b0, 32'hABCD0001, 1'b0, 0, 1'b0, 1'b0);
    check_eq("plan_addr", ({24'h0, ipte_h8} << 24) | ({24'h0, iva_h8} << 2), 32'h80000048);
    supervisor_mode = 1'b0;
    walk(1'b0, 1'b1, 32'h12340001, 1'b0, 0, 1'b0, 1'b0);
    supervisor_mode = 1'b1;
    walk(1'b1, 1'b1, 32'h55550003, 1'b0, 0, 1'b0, 1'b1);
    walk(1'b1, 1'b1, 32'h66660003, 1'b0, 0, 1'b0, 1'b1);
    walk(1'b1, 1'b1, 32'h77770003, 1'b0, 0, 1'b0, 1'b0);
    walk(1'b0, 1'b1, 32'hFFFF0003, 1'b1, 2, 1'b0, 1'b0);
    walk(1'b1, 1'b1, 32'h88880003, 1'b0, 5, 1'b1, 1'b0);

    // A miss withdrawn while disabled must never start a walk
    mmu_enable = 1'b0;
    i_miss = 1'b1;
    repeat (3) @(negedge clk);
    i_miss = 1'b0;
    mmu_enable = 1'b1;
    @(negedge clk);
    check_eq("ignored_miss", {30'b0, busy, bus.mem_req}, 32'h0);

`ifdef PTW_TIMEOUT_EN
    i_miss = 1'b1;
    @(negedge clk);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      check_eq("to_hold", {31'b0, bus.mem_req}, 32'h1);
    end
    @(negedge clk);
    check_eq("to_drop", {28'b0, bus.mem_req, i_done, i_fault, tlb_we}, 32'h6);
    i_miss = 1'b0;
    last_d = 1'b0;
    @(negedge clk);
    check_eq("to_idle", {31'b0, busy}, 32'h0);
`endif

    // Asynchronous reset in the middle of a bus read
    d_miss = 1'b1;
    @(negedge clk);
    check_eq("pre_rst_req", {31'b0, bus.mem_req}, 32'h1);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mid", {23'b0, bus.mem_req, fbus.mem_req, tlb_we, i_done, d_done, i_fault, d_fault, busy},
             32'h0);
    check_eq("rst_mid_addr", bus.mem_addr, 32'h0);
    d_miss = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    last_d = 1'b1;
    @(negedge clk);

    for (int n = 0; n < 40; n++) begin
      int r, w;
      r = $urandom_range(1, 3);
      w = $urandom_range(0, 4);
      ipte_h8 = 8'($urandom); dpte_h8 = 8'($urandom);
      iva_h8  = 8'($urandom); dva_h8  = 8'($urandom);
      supervisor_mode = 1'($urandom);
      walk(r[0], r[1], $urandom, ($urandom_range(0, 7) == 0), w,
           (w > 0) && ($urandom_range(0, 9) == 0), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
